mips_instr_encoder: RTL and testbench

//  Inverse of the control decoder. Accepts symbolic instruction requests (op index plus fields) over valid/ready.

---
 rtl/mips_instr_encoder.sv | 184 ++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic request to MIPS word encoder with FIFO drain into instruction memory (optional ENC_ILLEGAL_TRAP_EN)
module mips_instr_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              imem_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam int             PW      = $clog2(DEPTH);
  localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wr_q;
  logic              err_q;

  logic [5:0]  funct, opc;
  logic        is_r, is_shift, is_lui, is_j, illegal;
  logic [4:0]  rs_eff, sh_eff;
  logic [31:0] enc_word;
  logic        full, empty, accept, push, pop;

  // Decode op index into funct/opcode and pack the 32-bit instruction word
  always_comb begin
    funct    = 6'h00;
    opc      = 6'h00;
    is_r     = ~in_op[4];
    is_shift = (in_op == 5'd10) || (in_op == 5'd11) || (in_op == 5'd12);
    is_lui   = (in_op == 5'd28);
    is_j     = (in_op == 5'd27);
    illegal  = (in_op >= 5'd29);
    case (in_op)
      5'd0:  funct = 6'h20;
      5'd1:  funct = 6'h21;
      5'd2:  funct = 6'h22;
      5'd3:  funct = 6'h23;
      5'd4:  funct = 6'h24;
      5'd5:  funct = 6'h25;
      5'd6:  funct = 6'h26;
      5'd7:  funct = 6'h27;
      5'd8:  funct = 6'h2A;
      5'd9:  funct = 6'h2B;
      5'd10: funct = 6'h00;
      5'd11: funct = 6'h02;
      5'd12: funct = 6'h03;
      5'd13: funct = 6'h04;
      5'd14: funct = 6'h06;
      5'd15: funct = 6'h07;
      5'd16: opc   = 6'h23;
      5'd17: opc   = 6'h2B;
      5'd18: opc   = 6'h04;
      5'd19: opc   = 6'h05;
      5'd20: opc   = 6'h08;
      5'd21: opc   = 6'h09;
      5'd22: opc   = 6'h0C;
      5'd23: opc   = 6'h0D;
      5'd24: opc   = 6'h0E;
      5'd25: opc   = 6'h0A;
      5'd26: opc   = 6'h0B;
      5'd27: opc   = 6'h02;
      5'd28: opc   = 6'h0F;
      default: begin
        funct = 6'h00;
        opc   = 6'h00;
      end
    endcase
    rs_eff = (is_shift || is_lui) ? 5'd0 : in_rs;
    sh_eff = is_shift ? in_shamt : 5'd0;
    if (illegal)
      enc_word = 32'h0000_0000;
    else if (is_r)
      enc_word = {6'h00, rs_eff, in_rt, in_rd, sh_eff, funct};
    else if (is_j)
      enc_word = {opc, in_target};
    else
      enc_word = {opc, rs_eff, in_rt, in_imm};
  end

  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign in_ready = (state_q == ACCEPT) && !full;
  assign accept   = in_valid && in_ready;
`ifdef ENC_ILLEGAL_TRAP_EN
  assign push     = accept && !illegal && !start;
  assign err      = err_q;
`else
  assign push     = accept && !start;
  assign err      = 1'b0;
`endif
  assign imem_we    = !empty && (state_q != IDLE);
  assign pop        = imem_we && imem_ready && !start;
  assign imem_wdata = mem_q[rptr_q];
  assign imem_addr  = addr_q;
  assign wr_count   = wr_q;
  assign busy       = (state_q != IDLE);

  // Next state, occupancy and done pulse; start overrides everything else
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop && !push)
      cnt_d = cnt_q - 1'b1;
    if (start) begin
      state_d = ACCEPT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCEPT:  if (finish) state_d = DRAIN;
        DRAIN: begin
          if (empty) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers: state, FIFO pointers, write address, counters, err pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      addr_q  <= BASE_ADDR;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= accept && illegal && !start;
      if (start) begin
        wptr_q <= '0;
        rptr_q <= '0;
        addr_q <= BASE_ADDR;
        wr_q   <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
          addr_q <= addr_q + ADDR_W'(4);
          if (wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= enc_word;
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - directed self-checking bench for mips_instr_encoder
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid, in_ready;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] wr_count;

  int tests_run = 0;
  int fails     = 0;

  mips_instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .imem_ready(imem_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                          input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    step(); step();
    rst = 1'b0;
    step();
    tests_run++;
    if ({busy, imem_we, in_ready, done, err} !== 5'b0 || imem_addr !== 32'h0 || wr_count !== 16'h0) begin
      fails++;
      $display("FAIL reset: busy=%b we=%b rdy=%b done=%b err=%b addr=%h cnt=%h, want all 0",
               busy, imem_we, in_ready, done, err, imem_addr, wr_count);
    end
  endtask

  task automatic test_encode_basic();
    pulse_start();
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL start_accept: in_ready=%b busy=%b want 1 1", in_ready, busy);
    end
    imem_ready = 1'b1;
    push_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tests_run++;
    if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h0022_1820) begin
      fails++; $display("FAIL t1_add: we=%b addr=%h data=%h want 1 0 00221820", imem_we, imem_addr, imem_wdata);
    end
    step();
    tests_run++;
    if (imem_we !== 1'b0 || imem_addr !== 32'h4 || wr_count !== 16'd1) begin
      fails++; $display("FAIL t1_pop: we=%b addr=%h cnt=%0d want 0 4 1", imem_we, imem_addr, wr_count);
    end
  endtask

  task automatic test_encode_forms();
    logic [4:0]  op  [6] = '{5'd16, 5'd27, 5'd10, 5'd28, 5'd0, 5'd18};
    logic [4:0]  rs  [6] = '{5'd29, 5'd0, 5'd5, 5'd7, 5'd1, 5'd1};
    logic [4:0]  rt  [6] = '{5'd8, 5'd0, 5'd4, 5'd9, 5'd2, 5'd2};
    logic [4:0]  rd  [6] = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd3, 5'd0};
    logic [4:0]  sh  [6] = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd5, 5'd0};
    logic [15:0] imm [6] = '{16'h0004, 16'h0, 16'h0, 16'h1234, 16'h0, 16'hFFFF};
    logic [25:0] tgt [6] = '{26'h0, 26'h10, 26'h0, 26'h0, 26'h0, 26'h0};
    logic [31:0] exp [6] = '{32'h8FA8_0004, 32'h0800_0010, 32'h0004_10C0,
                             32'h3C09_1234, 32'h0022_1820, 32'h1022_FFFF};
    for (int i = 0; i < 6; i++) begin
      push_req(op[i], rs[i], rt[i], rd[i], sh[i], imm[i], tgt[i]);
      tests_run++;
      if (imem_we !== 1'b1 || imem_wdata !== exp[i]) begin
        fails++; $display("FAIL encode_%0d: we=%b data=%h want 1 %h", i, imem_we, imem_wdata, exp[i]);
      end
      step();
    end
    tests_run++;
    if (imem_addr !== 32'h1C || wr_count !== 16'd7) begin
      fails++; $display("FAIL encode_addr: addr=%h cnt=%0d want 1c 7", imem_addr, wr_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4] = '{32'h0022_1820, 32'h0085_3022, 32'h00E8_4825, 32'h2022_0010};
    pulse_start();
    imem_ready = 1'b0;
    push_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    push_req(5'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    push_req(5'd5, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0);
    push_req(5'd20, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0010, 26'h0);
    in_op = 5'd7; in_rs = 5'd3; in_rt = 5'd3; in_rd = 5'd3; in_shamt = 5'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== exp[0]) begin
        fails++; $display("FAIL bp_hold_%0d: rdy=%b we=%b addr=%h data=%h want 0 1 0 %h",
                          i, in_ready, imem_we, imem_addr, imem_wdata, exp[0]);
      end
      step();
    end
    in_valid = 1'b0;
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (imem_we !== 1'b1 || imem_addr !== 32'(i * 4) || imem_wdata !== exp[i]) begin
        fails++; $display("FAIL bp_drain_%0d: we=%b addr=%h data=%h want 1 %h %h",
                          i, imem_we, imem_addr, imem_wdata, 32'(i * 4), exp[i]);
      end
      step();
    end
    tests_run++;
    if (imem_we !== 1'b0 || wr_count !== 16'd4) begin
      fails++; $display("FAIL bp_count: we=%b cnt=%0d want 0 4", imem_we, wr_count);
    end
    push_req(5'd7, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0);
    tests_run++;
    if (imem_addr !== 32'h10 || imem_wdata !== 32'h0063_1827) begin
      fails++; $display("FAIL bp_fifth: addr=%h data=%h want 10 00631827", imem_addr, imem_wdata);
    end
    step();
  endtask

  task automatic test_drain_finish();
    int n_done = 0;
    int n_wr   = 0;
    pulse_start();
    imem_ready = 1'b0;
    push_req(5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    push_req(5'd1, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0);
    push_req(5'd1, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL drain_enter: rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (imem_we) n_wr++;
      if (done) n_done++;
      step();
    end
    tests_run++;
    if (n_wr != 3 || n_done != 1 || busy !== 1'b0 || wr_count !== 16'd3) begin
      fails++; $display("FAIL drain_done: writes=%0d dones=%0d busy=%b cnt=%0d want 3 1 0 3",
                        n_wr, n_done, busy, wr_count);
    end
    pulse_start();
    tests_run++;
    if (imem_addr !== 32'h0 || wr_count !== 16'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL restart: addr=%h cnt=%0d busy=%b want 0 0 1", imem_addr, wr_count, busy);
    end
  endtask

  task automatic test_illegal_reset();
    pulse_start();
    imem_ready = 1'b1;
    push_req(5'd30, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tests_run++;
`ifdef ENC_ILLEGAL_TRAP_EN
    if (err !== 1'b1 || imem_we !== 1'b0) begin
      fails++; $display("FAIL illegal_trap: err=%b we=%b want 1 0", err, imem_we);
    end
`else
    if (err !== 1'b0 || imem_we !== 1'b1 || imem_wdata !== 32'h0) begin
      fails++; $display("FAIL illegal_nop: err=%b we=%b data=%h want 0 1 0", err, imem_we, imem_wdata);
    end
`endif
    step();
    imem_ready = 1'b0;
    push_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    push_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    imem_ready = 1'b1;
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (imem_we !== 1'b0 || imem_addr !== 32'h0 || busy !== 1'b0 || wr_count !== 16'd0) begin
      fails++; $display("FAIL async_rst: we=%b addr=%h busy=%b cnt=%0d want 0 0 0 0",
                        imem_we, imem_addr, busy, wr_count);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_encode_basic();
    test_encode_forms();
    test_backpressure();
    test_drain_finish();
    test_illegal_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
